// File: rtl/spi_frame_monitor.sv
// rtl/spi_frame_monitor.sv - passive SPI frame monitor with frame capture, counting and sticky protocol errors
module spi_frame_monitor #(
    parameter int DATA_W = 10,
    parameter int NUM_SS = 1,
    parameter int CNT_W  = 16,
    localparam int CH_W  = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_SS-1:0] SS_n,
    input  logic              MOSI,
    input  logic              MISO,
    input  logic              err_clr,
    output logic              frame_valid,
    output logic [DATA_W-1:0] frame_data,
    output logic [CH_W-1:0]   frame_ch,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic              err_short,
    output logic              err_long,
    output logic              err_multi_ss,
    output logic              err_miso_idle
);

    localparam int BW = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    state_t            state;
    logic [BW-1:0]     bit_cnt;
    logic [DATA_W-1:0] shift_reg;
    logic [CH_W-1:0]   ch_q;
    logic              prev_idle;

    logic [3:0]        n_low;
    logic [CH_W-1:0]   sel_idx;
    logic              is_idle;
    logic              is_sel;
    logic              is_multi;
    logic              ch_change;

    // Classify the slave-select bus: how many channels are low and which one
    always_comb begin
        n_low   = '0;
        sel_idx = '0;
        for (int i = 0; i < NUM_SS; i++) begin
            if (!SS_n[i]) begin
                n_low   = n_low + 4'd1;
                sel_idx = CH_W'(i);
            end
        end
    end

    assign is_idle   = (n_low == 4'd0);
    assign is_sel    = (n_low == 4'd1);
    assign is_multi  = (n_low > 4'd1);
    // Another channel taking over mid-frame is as bad as two selects at once
    assign ch_change = is_sel && (sel_idx != ch_q);

    // Frame FSM, capture registers and sticky error flags.
    // err_clr is applied first so that a same-edge set (later NBA) wins.
    // In HOLD, bit_cnt == DATA_W marks a frame not yet published; it is
    // zeroed once frame_valid fires, so later selected edges mean err_long.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            shift_reg     <= '0;
            ch_q          <= '0;
            prev_idle     <= 1'b0;
            frame_valid   <= 1'b0;
            frame_data    <= '0;
            frame_ch      <= '0;
            frame_cnt     <= '0;
            err_short     <= 1'b0;
            err_long      <= 1'b0;
            err_multi_ss  <= 1'b0;
            err_miso_idle <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            prev_idle   <= is_idle;

            if (err_clr) begin
                err_short     <= 1'b0;
                err_long      <= 1'b0;
                err_multi_ss  <= 1'b0;
                err_miso_idle <= 1'b0;
            end

            if (prev_idle && is_idle && MISO) begin
                err_miso_idle <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (is_multi) begin
                        err_multi_ss <= 1'b1;
                    end else if (is_sel) begin
                        ch_q      <= sel_idx;
                        shift_reg <= {{(DATA_W-1){1'b0}}, MOSI};
                        bit_cnt   <= BW'(1);
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (is_multi || ch_change) begin
                        err_multi_ss <= 1'b1;
                        bit_cnt      <= '0;
                        shift_reg    <= '0;
                        state        <= IDLE;
                    end else if (is_idle) begin
                        err_short <= 1'b1;
                        bit_cnt   <= '0;
                        shift_reg <= '0;
                        state     <= IDLE;
                    end else begin
                        shift_reg <= {shift_reg[DATA_W-2:0], MOSI};
                        bit_cnt   <= bit_cnt + BW'(1);
                        if (bit_cnt == BW'(DATA_W - 1)) begin
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (is_multi || ch_change) begin
                        err_multi_ss <= 1'b1;
                        bit_cnt      <= '0;
                        state        <= IDLE;
                    end else begin
                        if (bit_cnt == BW'(DATA_W)) begin
                            frame_valid <= 1'b1;
                            frame_data  <= shift_reg;
                            frame_ch    <= ch_q;
                            if (frame_cnt != {CNT_W{1'b1}}) begin
                                frame_cnt <= frame_cnt + CNT_W'(1);
                            end
                            bit_cnt <= '0;
                        end else if (is_sel) begin
                            err_long <= 1'b1;
                        end
                        if (is_idle) begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    bit_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_frame_monitor.sv
// tb/tb_spi_frame_monitor.sv - directed self-checking bench for spi_frame_monitor
module tb_spi_frame_monitor;

    localparam int DATA_W = 10;
    localparam int NUM_SS = 4;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NUM_SS-1:0] SS_n;
    logic              MOSI;
    logic              MISO;
    logic              err_clr;
    logic              frame_valid;
    logic [DATA_W-1:0] frame_data;
    logic [1:0]        frame_ch;
    logic [CNT_W-1:0]  frame_cnt;
    logic              err_short;
    logic              err_long;
    logic              err_multi_ss;
    logic              err_miso_idle;

    int tests = 0;
    int fails = 0;
    int pulses;
    int pulse_at;
    int edge_no;

    spi_frame_monitor #(.DATA_W(DATA_W), .NUM_SS(NUM_SS), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
        .err_clr(err_clr), .frame_valid(frame_valid), .frame_data(frame_data),
        .frame_ch(frame_ch), .frame_cnt(frame_cnt), .err_short(err_short),
        .err_long(err_long), .err_multi_ss(err_multi_ss), .err_miso_idle(err_miso_idle)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        edge_no++;
        if (frame_valid === 1'b1) begin
            pulses++;
            pulse_at = edge_no;
        end
    endtask

    task automatic drive(input logic [3:0] ss, input logic mosi);
        SS_n = ss;
        MOSI = mosi;
        tick();
    endtask

    task automatic run_frame(input int ch, input logic [9:0] data, input int nsel);
        logic [3:0] ss;
        logic       b;
        ss = ~(4'b0001 << ch);
        pulses = 0;
        pulse_at = 0;
        edge_no = 0;
        for (int i = 0; i < nsel; i++) begin
            b = (i < 10) ? data[9-i] : 1'b1;
            drive(ss, b);
        end
        drive(4'hF, 1'b0);
    endtask

    task automatic clear_errors();
        err_clr = 1'b1;
        drive(4'hF, 1'b0);
        err_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; SS_n = 4'hF; MOSI = 1'b0; MISO = 1'b0; err_clr = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        tests++; if (frame_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", frame_valid); end
        tests++; if (frame_data !== 10'h0) begin fails++; $display("FAIL reset_data: got %h expected 000", frame_data); end
        tests++; if (frame_cnt !== 4'h0) begin fails++; $display("FAIL reset_cnt: got %h expected 0", frame_cnt); end
        tests++; if ({err_short, err_long, err_multi_ss, err_miso_idle} !== 4'b0) begin fails++;
            $display("FAIL reset_errs: got %b expected 0000", {err_short, err_long, err_multi_ss, err_miso_idle}); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic_frame();
        run_frame(0, 10'h2CE, 10);
        tests++; if (pulses !== 1) begin fails++; $display("FAIL basic_pulses: got %0d expected 1", pulses); end
        tests++; if (pulse_at !== 11) begin fails++; $display("FAIL basic_pulse_edge: got %0d expected 11", pulse_at); end
        tests++; if (frame_data !== 10'h2CE) begin fails++; $display("FAIL basic_data: got %h expected 2ce", frame_data); end
        tests++; if (frame_ch !== 2'd0) begin fails++; $display("FAIL basic_ch: got %0d expected 0", frame_ch); end
        tests++; if (frame_cnt !== 4'd1) begin fails++; $display("FAIL basic_cnt: got %0d expected 1", frame_cnt); end
        tests++; if ({err_short, err_long, err_multi_ss, err_miso_idle} !== 4'b0) begin fails++;
            $display("FAIL basic_errs: got %b expected 0000", {err_short, err_long, err_multi_ss, err_miso_idle}); end
        drive(4'hF, 1'b0);
        tests++; if (frame_valid !== 1'b0) begin fails++; $display("FAIL basic_pulse_width: got %b expected 0", frame_valid); end
    endtask

    task automatic test_short_frame();
        run_frame(0, 10'h3FF, 6);
        tests++; if (err_short !== 1'b1) begin fails++; $display("FAIL short_err: got %b expected 1", err_short); end
        tests++; if (pulses !== 0) begin fails++; $display("FAIL short_pulses: got %0d expected 0", pulses); end
        tests++; if (frame_cnt !== 4'd1) begin fails++; $display("FAIL short_cnt: got %0d expected 1", frame_cnt); end
        tests++; if (frame_data !== 10'h2CE) begin fails++; $display("FAIL short_data_held: got %h expected 2ce", frame_data); end
        clear_errors();
        tests++; if (err_short !== 1'b0) begin fails++; $display("FAIL short_clr: got %b expected 0", err_short); end
    endtask

    task automatic test_long_frame();
        run_frame(0, 10'h155, 12);
        tests++; if (pulses !== 1) begin fails++; $display("FAIL long_pulses: got %0d expected 1", pulses); end
        tests++; if (err_long !== 1'b1) begin fails++; $display("FAIL long_err: got %b expected 1", err_long); end
        tests++; if (frame_data !== 10'h155) begin fails++; $display("FAIL long_data: got %h expected 155", frame_data); end
        tests++; if (frame_cnt !== 4'd2) begin fails++; $display("FAIL long_cnt: got %0d expected 2", frame_cnt); end
        clear_errors();
    endtask

    task automatic test_multi_ss();
        pulses = 0;
        drive(4'b1100, 1'b1);
        tests++; if (err_multi_ss !== 1'b1) begin fails++; $display("FAIL multi_err: got %b expected 1", err_multi_ss); end
        drive(4'hF, 1'b0);
        run_frame(2, 10'h3A5, 10);
        tests++; if (pulses !== 1 || pulse_at !== 11) begin fails++;
            $display("FAIL multi_recover: got %0d pulses at %0d expected 1 at 11", pulses, pulse_at); end
        tests++; if (frame_ch !== 2'd2) begin fails++; $display("FAIL multi_ch: got %0d expected 2", frame_ch); end
        tests++; if (frame_data !== 10'h3A5) begin fails++; $display("FAIL multi_data: got %h expected 3a5", frame_data); end
        tests++; if (frame_cnt !== 4'd3) begin fails++; $display("FAIL multi_cnt: got %0d expected 3", frame_cnt); end
        clear_errors();
    endtask

    task automatic test_ch_change();
        pulses = 0;
        for (int i = 0; i < 3; i++) drive(4'b1110, 1'b1);
        drive(4'b1101, 1'b1);
        drive(4'hF, 1'b0);
        tests++; if (err_multi_ss !== 1'b1) begin fails++; $display("FAIL chchg_err: got %b expected 1", err_multi_ss); end
        tests++; if (err_short !== 1'b0) begin fails++; $display("FAIL chchg_short: got %b expected 0", err_short); end
        tests++; if (pulses !== 0 || frame_cnt !== 4'd3) begin fails++;
            $display("FAIL chchg_nocount: got %0d pulses cnt %0d expected 0 pulses cnt 3", pulses, frame_cnt); end
        clear_errors();
    endtask

    task automatic test_clr_priority();
        for (int i = 0; i < 4; i++) drive(4'b1110, 1'b0);
        err_clr = 1'b1;
        drive(4'hF, 1'b0);
        tests++; if (err_short !== 1'b1) begin fails++; $display("FAIL clr_same_edge: got %b expected 1", err_short); end
        drive(4'hF, 1'b0);
        err_clr = 1'b0;
        tests++; if (err_short !== 1'b0) begin fails++; $display("FAIL clr_next_edge: got %b expected 0", err_short); end
        tests++; if (frame_cnt !== 4'd3 || frame_data !== 10'h3A5) begin fails++;
            $display("FAIL clr_no_side: got cnt %0d data %h expected 3 3a5", frame_cnt, frame_data); end
    endtask

    task automatic test_miso_idle();
        drive(4'b1110, 1'b0);
        MISO = 1'b1;
        drive(4'hF, 1'b0);
        tests++; if (err_miso_idle !== 1'b0) begin fails++; $display("FAIL miso_after_sel: got %b expected 0", err_miso_idle); end
        drive(4'hF, 1'b0);
        tests++; if (err_miso_idle !== 1'b1) begin fails++; $display("FAIL miso_idle: got %b expected 1", err_miso_idle); end
        MISO = 1'b0;
        clear_errors();
    endtask

    task automatic test_saturate_and_async_reset();
        logic [9:0] d;
        for (int k = 0; k < 12; k++) begin
            d = 10'(k * 37 + 5);
            run_frame(k % 4, d, 10);
        end
        tests++; if (frame_cnt !== 4'd15) begin fails++; $display("FAIL sat_cnt: got %0d expected 15", frame_cnt); end
        tests++; if (frame_data !== 10'h19C || frame_ch !== 2'd3) begin fails++;
            $display("FAIL sat_last: got %h ch %0d expected 19c ch 3", frame_data, frame_ch); end
        run_frame(1, 10'h0F0, 10);
        tests++; if (frame_cnt !== 4'd15 || pulses !== 1) begin fails++;
            $display("FAIL sat_hold: got cnt %0d pulses %0d expected 15 1", frame_cnt, pulses); end
        for (int i = 0; i < 5; i++) drive(4'b1110, 1'b1);
        rst_n = 1'b0;
        #1;
        tests++; if ({frame_valid, frame_data, frame_ch, frame_cnt} !== 17'h0) begin fails++;
            $display("FAIL async_reset: got %h expected 0", {frame_valid, frame_data, frame_ch, frame_cnt}); end
        SS_n = 4'hF;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        run_frame(1, 10'h201, 10);
        tests++; if (pulses !== 1 || frame_data !== 10'h201 || frame_ch !== 2'd1 || frame_cnt !== 4'd1) begin fails++;
            $display("FAIL post_reset_frame: got p%0d %h ch%0d cnt%0d expected p1 201 ch1 cnt1", pulses, frame_data, frame_ch, frame_cnt); end
        tests++; if ({err_short, err_long, err_multi_ss, err_miso_idle} !== 4'b0) begin fails++;
            $display("FAIL post_reset_errs: got %b expected 0000", {err_short, err_long, err_multi_ss, err_miso_idle}); end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_short_frame();
        test_long_frame();
        test_multi_ss();
        test_ch_change();
        test_clr_priority();
        test_miso_idle();
        test_saturate_and_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_frame_monitor.md
SPI_FRAME_MONITOR -- requirements
Module: spi_frame_monitor

Parameters
REQ-001 DATA_W, default 10, SHALL set the frame length in bits (range 2..32).
REQ-002 NUM_SS, default 1, SHALL set the number of slave-select channels (range 1..8).
REQ-003 CNT_W, default 16, SHALL set the frame counter width (range 4..32).

Interface
REQ-004 clk  in  1  SHALL be the single clock; all sampling is on its rising edge.
REQ-005 rst_n  in  1  SHALL be the reset: asynchronous assert, active-low.
REQ-006 SS_n  in  NUM_SS  SHALL carry the active-low slave selects, one bit per channel.
REQ-007 MOSI  in  1  SHALL be the master-to-slave serial data.
REQ-008 MISO  in  1  SHALL be the slave-to-master serial data.
REQ-009 err_clr  in  1  SHALL be a synchronous pulse that clears all sticky error flags.
REQ-010 frame_valid  out  1  SHALL be a one-cycle pulse marking a completed frame.
REQ-011 frame_data  out  DATA_W  SHALL hold the last completed MOSI frame, MSB first.
REQ-012 frame_ch  out  $clog2(NUM_SS) (min 1)  SHALL hold the channel index of the last completed frame.
REQ-013 frame_cnt  out  CNT_W  SHALL count completed frames and saturate at all-ones.
REQ-014 err_short, err_long, err_multi_ss, err_miso_idle  out  1 each  SHALL be sticky error flags.

Function
REQ-015 "Selected" SHALL mean exactly one SS_n bit is 0. "Multi" SHALL mean two or more SS_n bits are 0. "Idle" SHALL mean all SS_n bits are 1.
REQ-016 The FSM SHALL have three states: IDLE, SHIFT and HOLD.
REQ-017 In IDLE, on a Selected edge, the FSM SHALL latch the channel index, shift in MOSI, set bit_cnt to 1 and enter SHIFT.
REQ-018 In SHIFT, on each edge where the latched channel stays Selected, the FSM SHALL shift in MOSI (MSB first) and increment bit_cnt.
REQ-019 When bit_cnt reaches DATA_W, the FSM SHALL enter HOLD.
REQ-020 On the edge after the DATA_W-th bit, frame_valid SHALL be 1 for exactly one cycle.
REQ-021 On that same edge, frame_data, frame_ch and frame_cnt (+1, saturating) SHALL update.
REQ-022 In SHIFT, if Idle is seen, the FSM SHALL set err_short and return to IDLE; no frame_valid, no count.
REQ-023 In HOLD, a Selected edge SHALL set err_long; captured data SHALL be unaffected and frame_valid SHALL not repeat.
REQ-024 In HOLD, Idle SHALL return the FSM to IDLE.
REQ-025 In any state, Multi SHALL set err_multi_ss and force IDLE; a frame in progress SHALL be discarded.
REQ-026 A change of Selected channel during SHIFT or HOLD SHALL be treated as Multi.
REQ-027 MISO=1 on an edge where SS_n was Idle on the previous edge and is Idle on the current edge SHALL set err_miso_idle.
REQ-028 When err_clr and an error set occur on the same edge, the set SHALL win.
REQ-029 err_clr SHALL not affect frame_cnt, frame_data or the FSM state.
REQ-030 frame_data SHALL hold its value until the next completed frame.

Reset
REQ-031 While rst_n=0, the FSM SHALL be IDLE, bit_cnt and the shift register 0, and every output 0.
REQ-032 Reset asserted mid-frame SHALL discard the partial frame with no frame_valid and no error flag set.
REQ-033 The first edge after reset release SHALL be evaluated as a normal edge.

Verification
REQ-034 DATA_W=10: SS_n[0]=0 for 10 cycles, MOSI=1,0,1,1,0,0,1,1,1,0, then SS_n=1 -> one frame_valid pulse on the edge after bit 10, frame_data=0x2CE, frame_ch=0, frame_cnt=1, no errors.
REQ-035 SS_n low for 6 cycles, then high -> err_short=1, frame_valid never pulses, frame_cnt unchanged.
REQ-036 SS_n low for 12 cycles -> frame_valid pulses once, then err_long=1, frame_data equals the first 10 bits.
REQ-037 NUM_SS=4: SS_n=4'b1100 -> err_multi_ss=1, FSM in IDLE; next a clean frame on channel 2 -> frame_ch=2.
REQ-038 err_clr pulse on the same edge as a short-frame abort -> err_short stays 1; err_clr one cycle later -> 0.
REQ-039 CNT_W=4, 17 clean frames -> frame_cnt=15; rst_n pulled low at bit 5 of the 18th frame -> all outputs 0 asynchronously.
